// File: rtl/fp16_accumulator.sv
// Iterative fp16 running-sum accumulator: accept, align, add and normalize take one cycle each.
// Operands with exponent 0 are zero, there are no subnormals, and results saturate at the largest finite value.
module fp16_accumulator #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [15:0]          product,
  input  logic                 product_valid,
  input  logic                 last,
  output logic                 in_ready,
  input  logic                 acc_clear,
  output logic [15:0]          sum,
  output logic                 sum_valid,
  output logic [CNT_WIDTH-1:0] term_count,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, ADD = 2'd2, NORM = 2'd3} state_t;

  state_t      state, state_next;
  logic [15:0] acc_r, op_r;
  logic        last_r;
  logic        big_sign_r, sub_r;
  logic [4:0]  big_exp_r;
  logic [10:0] big_sig_r, small_sig_r;
  logic [11:0] raw_r;

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    logic       found;
    n = 4'd0;
    found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!found && v[i]) begin
        found = 1'b1;
      end else if (!found) begin
        n = n + 4'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  assign in_ready = reset_b & (state == IDLE) & ~acc_clear;
  assign busy     = (state != IDLE);

  // Operand ordering and alignment, fed by the accumulator and the captured product
  logic        a_zero, b_zero, a_big;
  logic [14:0] mag_a, mag_b;
  logic [10:0] sig_a, sig_b, al_big, al_small_raw, al_small;
  logic [4:0]  al_diff;
  always_comb begin
    a_zero       = (acc_r[14:10] == 5'd0);
    b_zero       = (op_r[14:10] == 5'd0);
    mag_a        = a_zero ? 15'd0 : acc_r[14:0];
    mag_b        = b_zero ? 15'd0 : op_r[14:0];
    sig_a        = a_zero ? 11'd0 : {1'b1, acc_r[9:0]};
    sig_b        = b_zero ? 11'd0 : {1'b1, op_r[9:0]};
    a_big        = (mag_a >= mag_b);
    al_big       = a_big ? sig_a : sig_b;
    al_small_raw = a_big ? sig_b : sig_a;
    al_diff      = a_big ? (mag_a[14:10] - mag_b[14:10]) : (mag_b[14:10] - mag_a[14:10]);
    if (al_diff >= 5'd11) begin
      al_small = 11'd0;
    end else begin
      al_small = al_small_raw >> al_diff;
    end
  end

  // Normalization and special-result handling of the raw sum
  logic               [3:0]  nm_lz;
  logic               [10:0] nm_shift;
  logic               [9:0]  nm_man;
  logic signed        [6:0]  nm_exp;
  logic               [15:0] result;
  always_comb begin
    nm_lz    = lzc11(raw_r[10:0]);
    nm_shift = raw_r[10:0] << nm_lz;
    if (raw_r[11]) begin
      nm_man = raw_r[10:1];
      nm_exp = $signed({2'b00, big_exp_r}) + 7'sd1;
    end else begin
      nm_man = nm_shift[9:0];
      nm_exp = $signed({2'b00, big_exp_r}) - $signed({3'b000, nm_lz});
    end
    if (raw_r == 12'd0) begin
      result = 16'h0000;
    end else if (nm_exp <= 7'sd0) begin
      result = 16'h0000;
    end else if (nm_exp >= 7'sd31) begin
      result = {big_sign_r, 15'h7BFF};
    end else begin
      result = {big_sign_r, nm_exp[4:0], nm_man};
    end
  end

  // Next-state logic; a clear aborts from any state
  always_comb begin
    state_next = state;
    if (acc_clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = (product_valid && in_ready) ? ALIGN : IDLE;
        ALIGN:   state_next = ADD;
        ADD:     state_next = NORM;
        NORM:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath stages, accumulator, result and term counter
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      acc_r       <= 16'h0000;
      op_r        <= 16'h0000;
      last_r      <= 1'b0;
      big_sign_r  <= 1'b0;
      sub_r       <= 1'b0;
      big_exp_r   <= 5'd0;
      big_sig_r   <= 11'd0;
      small_sig_r <= 11'd0;
      raw_r       <= 12'd0;
      sum         <= 16'h0000;
      sum_valid   <= 1'b0;
      term_count  <= {CNT_WIDTH{1'b0}};
    end else if (acc_clear) begin
      acc_r      <= 16'h0000;
      term_count <= {CNT_WIDTH{1'b0}};
      sum_valid  <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (product_valid && in_ready) begin
            op_r   <= product;
            last_r <= last;
          end
        end
        ALIGN: begin
          big_sign_r  <= a_big ? acc_r[15] : op_r[15];
          big_exp_r   <= a_big ? acc_r[14:10] : op_r[14:10];
          big_sig_r   <= al_big;
          small_sig_r <= al_small;
          sub_r       <= (acc_r[15] != op_r[15]);
        end
        ADD: begin
          raw_r <= sub_r ? ({1'b0, big_sig_r} - {1'b0, small_sig_r})
                         : ({1'b0, big_sig_r} + {1'b0, small_sig_r});
        end
        NORM: begin
          if (last_r) begin
            sum        <= result;
            sum_valid  <= 1'b1;
            acc_r      <= 16'h0000;
            term_count <= {CNT_WIDTH{1'b0}};
          end else begin
            acc_r <= result;
            if (term_count != {CNT_WIDTH{1'b1}}) begin
              term_count <= term_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Directed bench for fp16_accumulator: table of two-term sums plus back-pressure, clear and reset sequences.
module tb_fp16_accumulator;

  logic        clk;
  logic        reset_b;
  logic [15:0] product;
  logic        product_valid;
  logic        last;
  logic        in_ready;
  logic        acc_clear;
  logic [15:0] sum;
  logic        sum_valid;
  logic [7:0]  term_count;
  logic        busy;

  int errors;
  int checks;

  fp16_accumulator #(.CNT_WIDTH(8)) dut (
    .clk(clk), .reset_b(reset_b), .product(product), .product_valid(product_valid),
    .last(last), .in_ready(in_ready), .acc_clear(acc_clear), .sum(sum),
    .sum_valid(sum_valid), .term_count(term_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expect_sum;
  } vec_t;

  vec_t vecs [0:8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic accept(input logic [15:0] p, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    product = p;
    last = l;
    product_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    product_valid = 1'b0;
  endtask

  task automatic finish_mid();
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_pulse", {31'd0, sum_valid}, 32'd0);
    check("mid_term_count", {24'd0, term_count}, 32'd1);
  endtask

  task automatic finish_last(input logic [15:0] expect_sum);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("pulse_timing", {31'd0, sum_valid}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) check("sum_value", {16'd0, sum}, {16'd0, expect_sum});
    end
    check("term_count_cleared", {24'd0, term_count}, 32'd0);
  endtask

  initial begin
    int busy_cycles;
    int guard;
    logic ready_bad;
    logic saw_pulse;

    errors = 0;
    checks = 0;
    vecs[0] = '{16'h3C00, 16'h3C00, 16'h4000};
    vecs[1] = '{16'h3C00, 16'hBC00, 16'h0000};
    vecs[2] = '{16'h8000, 16'h0000, 16'h0000};
    vecs[3] = '{16'h3C00, 16'h1000, 16'h3C00};
    vecs[4] = '{16'h3C00, 16'h3800, 16'h3E00};
    vecs[5] = '{16'h7BFF, 16'h7BFF, 16'h7BFF};
    vecs[6] = '{16'hFBFF, 16'hFBFF, 16'hFBFF};
    vecs[7] = '{16'h0401, 16'h8400, 16'h0000};
    vecs[8] = '{16'h4000, 16'hBC00, 16'h3C00};

    reset_b = 1'b0;
    product = 16'h0000;
    product_valid = 1'b0;
    last = 1'b0;
    acc_clear = 1'b0;
    #12;
    check("reset_sum", {16'd0, sum}, 32'd0);
    check("reset_sum_valid", {31'd0, sum_valid}, 32'd0);
    check("reset_term_count", {24'd0, term_count}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_b = 1'b1;
    #1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      accept(vecs[i].a, 1'b0);
      finish_mid();
      accept(vecs[i].b, 1'b1);
      finish_last(vecs[i].expect_sum);
    end

    // Back-pressure: valid held high through three terms
    @(negedge clk);
    product = 16'h3C00;
    last = 1'b0;
    product_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("bp_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      if (t == 0) begin
        product = 16'h3C00;
        last = 1'b0;
      end else if (t == 1) begin
        product = 16'h4000;
        last = 1'b1;
      end else begin
        product_valid = 1'b0;
      end
      busy_cycles = 0;
      ready_bad = 1'b0;
      @(negedge clk);
      while (busy && busy_cycles < 10) begin
        if (in_ready) ready_bad = 1'b1;
        busy_cycles++;
        @(negedge clk);
      end
      check("bp_busy_cycles", busy_cycles, 32'd3);
      check("bp_ready_low_while_busy", {31'd0, ready_bad}, 32'd0);
      check("bp_pulse", {31'd0, sum_valid}, (t == 2) ? 32'd1 : 32'd0);
    end
    check("bp_sum", {16'd0, sum}, 32'h4400);

    // Clear while in flight discards the term and the accumulator
    accept(16'h3C00, 1'b0);
    finish_mid();
    accept(16'h3C00, 1'b0);
    @(negedge clk);
    acc_clear = 1'b1;
    #1;
    check("clear_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    acc_clear = 1'b0;
    check("clear_busy", {31'd0, busy}, 32'd0);
    check("clear_term_count", {24'd0, term_count}, 32'd0);
    saw_pulse = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (sum_valid) saw_pulse = 1'b1;
    end
    check("clear_no_pulse", {31'd0, saw_pulse}, 32'd0);
    check("clear_sum_holds", {16'd0, sum}, 32'h4400);

    // Clear wins over a simultaneous product in IDLE
    @(negedge clk);
    acc_clear = 1'b1;
    product = 16'h3C00;
    last = 1'b1;
    product_valid = 1'b1;
    #1;
    check("clear_wins_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    acc_clear = 1'b0;
    product_valid = 1'b0;
    check("clear_wins_idle", {31'd0, busy}, 32'd0);
    accept(16'h4000, 1'b1);
    finish_last(16'h4000);

    // Reset in the middle of an operation
    accept(16'h3C00, 1'b0);
    finish_mid();
    accept(16'h3C00, 1'b1);
    #2;
    reset_b = 1'b0;
    #1;
    check("midrst_sum", {16'd0, sum}, 32'd0);
    check("midrst_sum_valid", {31'd0, sum_valid}, 32'd0);
    check("midrst_term_count", {24'd0, term_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset_b = 1'b1;
    saw_pulse = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (sum_valid) saw_pulse = 1'b1;
    end
    check("midrst_no_pulse", {31'd0, saw_pulse}, 32'd0);

    accept(16'h3C00, 1'b0);
    finish_mid();
    accept(16'h3C00, 1'b1);
    finish_last(16'h4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
